// File: rtl/pu_multi_lane_controller.sv
// pu_multi_lane_controller: sequences NUM_LANES PU lanes through buffer fill, operation and drain
// Inputs : clock, reset (sync, active-high), start, abort, lane_mask, and per-lane MPE/buffer
//          status (mpe_out_ready, mpe_busy, weight_valid, unique_*, new_weight, rep_*, is_index,
//          idx_filled, lane_finished).
// Outputs: per-lane enables for MPE/unique/rep/idx, sticky lane_done, busy, done pulse,
//          sticky timeout_err, op_cycles (saturating OPERATE-cycle count), state_o.
module pu_multi_lane_controller #(
  parameter int NUM_LANES    = 4,
  parameter int FILL_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic [NUM_LANES-1:0] mpe_out_ready,
  input  logic [NUM_LANES-1:0] mpe_busy,
  input  logic [NUM_LANES-1:0] weight_valid,
  input  logic [NUM_LANES-1:0] unique_busy,
  input  logic [NUM_LANES-1:0] unique_filled,
  input  logic [NUM_LANES-1:0] new_weight,
  input  logic [NUM_LANES-1:0] rep_busy,
  input  logic [NUM_LANES-1:0] rep_filled,
  input  logic [NUM_LANES-1:0] is_index,
  input  logic [NUM_LANES-1:0] idx_filled,
  input  logic [NUM_LANES-1:0] lane_finished,
  output logic [NUM_LANES-1:0] mpe_enable,
  output logic [NUM_LANES-1:0] unique_enable,
  output logic [NUM_LANES-1:0] rep_enable,
  output logic [NUM_LANES-1:0] idx_enable,
  output logic [NUM_LANES-1:0] lane_done,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     op_cycles,
  output logic [2:0]           state_o
);
  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, OPERATE = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;
  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] mask_q, mask_d, lane_done_q, lane_done_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]     op_cycles_q, op_cycles_d;
  logic [TW-1:0]        fill_timer_q, fill_timer_d;
  logic [NUM_LANES-1:0] act;
  logic                 fill_ok, all_fin, run;
  // unmasked lanes never hold up fill completion or the move to DRAIN
  assign fill_ok = &(~mask_q | (rep_filled & unique_filled & idx_filled));
  assign all_fin = &(~mask_q | lane_done_q | lane_finished);
  assign run     = state_q inside {FILL, OPERATE, DRAIN};
  // abort silences every lane in the same cycle it is raised
  assign act     = (run && !abort) ? mask_q & ~lane_done_q : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      lane_done_q   <= '0;
      timeout_err_q <= 1'b0;
      op_cycles_q   <= '0;
      fill_timer_q  <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      lane_done_q   <= lane_done_d;
      timeout_err_q <= timeout_err_d;
      op_cycles_q   <= op_cycles_d;
      fill_timer_q  <= fill_timer_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    lane_done_d   = lane_done_q;
    timeout_err_d = timeout_err_q;
    op_cycles_d   = op_cycles_q;
    fill_timer_d  = fill_timer_q;
    case (state_q)
      IDLE: if (start) begin
        mask_d        = lane_mask;
        lane_done_d   = '0;
        op_cycles_d   = '0;
        fill_timer_d  = '0;
        timeout_err_d = 1'b0;
        state_d       = |lane_mask ? FILL : DONE;
      end
      FILL: begin
        fill_timer_d = fill_timer_q + TW'(1);
        // a fill completing on the timeout cycle still wins; abort suppresses the error flag
        if (fill_ok) state_d = OPERATE;
        else if (fill_timer_q == TW'(FILL_TIMEOUT - 1)) begin
          state_d       = IDLE;
          timeout_err_d = ~abort;
        end
      end
      OPERATE: begin
        op_cycles_d = &op_cycles_q ? op_cycles_q : op_cycles_q + CNT_W'(1);
        lane_done_d = lane_done_q | (lane_finished & mask_q);
        if (all_fin) state_d = DRAIN;
      end
      DRAIN:   if (~|(mpe_busy & mask_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (run && abort) state_d = IDLE;
  end
  always_comb begin
    rep_enable    = act & (state_q == FILL ? ~rep_filled : state_q == OPERATE ? is_index & ~unique_busy : '0);
    unique_enable = act & (state_q == FILL ? ~unique_filled : state_q == OPERATE ? new_weight & mpe_out_ready : '0);
    idx_enable    = act & (state_q == FILL ? ~idx_filled : state_q == OPERATE ? ~rep_busy : '0);
    mpe_enable    = act & (state_q == OPERATE ? weight_valid : '0);
    lane_done     = lane_done_q;
    busy          = state_q != IDLE;
    done          = state_q == DONE;
    timeout_err   = timeout_err_q;
    op_cycles     = op_cycles_q;
    state_o       = state_q;
  end
endmodule

// File: tb/tb_pu_multi_lane_controller.sv
// tb_pu_multi_lane_controller: directed test-plan runs plus random traffic checked against a lane-level model
module tb_pu_multi_lane_controller;
  localparam int N = 4, FT = 8, CW = 4;
  logic clock = 0, reset = 1, start = 0, abort = 0;
  logic [N-1:0] lane_mask = 0, mpe_out_ready = 0, mpe_busy = 0, weight_valid = 0, unique_busy = 0;
  logic [N-1:0] unique_filled = 0, new_weight = 0, rep_busy = 0, rep_filled = 0, is_index = 0;
  logic [N-1:0] idx_filled = 0, lane_finished = 0;
  logic [N-1:0] mpe_enable, unique_enable, rep_enable, idx_enable, lane_done;
  logic busy, done, timeout_err;
  logic [CW-1:0] op_cycles;
  logic [2:0] state_o;
  pu_multi_lane_controller #(.NUM_LANES(N), .FILL_TIMEOUT(FT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .lane_mask(lane_mask),
    .mpe_out_ready(mpe_out_ready), .mpe_busy(mpe_busy), .weight_valid(weight_valid),
    .unique_busy(unique_busy), .unique_filled(unique_filled), .new_weight(new_weight),
    .rep_busy(rep_busy), .rep_filled(rep_filled), .is_index(is_index), .idx_filled(idx_filled),
    .lane_finished(lane_finished), .mpe_enable(mpe_enable), .unique_enable(unique_enable),
    .rep_enable(rep_enable), .idx_enable(idx_enable), .lane_done(lane_done), .busy(busy),
    .done(done), .timeout_err(timeout_err), .op_cycles(op_cycles), .state_o(state_o));
  always #5 clock = ~clock;
  int total = 0, bad = 0, done_cnt = 0, dc0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: phase uses the state_o encoding (0 idle,1 fill,2 operate,3 drain,4 done)
  int m_st, m_ops, m_fcnt;
  logic [N-1:0] m_mask, m_ldone, e_rep, e_uni, e_idx, e_mpe, leak;
  bit m_terr, m_valid = 0, ok, fin_all, a;
  always @(posedge clock) begin
    if (reset) begin
      m_st = 0; m_mask = 0; m_ldone = 0; m_terr = 0; m_ops = 0; m_fcnt = 0; m_valid = 1;
    end else begin
      ok = 1; fin_all = 1;
      for (int i = 0; i < N; i++) if (m_mask[i]) begin
        ok = ok && rep_filled[i] && unique_filled[i] && idx_filled[i];
        fin_all = fin_all && (m_ldone[i] || lane_finished[i]);
      end
      case (m_st)
        0: if (start) begin
          m_mask = lane_mask; m_ldone = 0; m_ops = 0; m_fcnt = 0; m_terr = 0;
          m_st = (lane_mask == 0) ? 4 : 1;
        end
        1: begin
          if (abort) m_st = 0;
          else if (ok) m_st = 2;
          else if (m_fcnt == FT - 1) begin m_terr = 1; m_st = 0; end
          m_fcnt++;
        end
        2: begin
          if (m_ops < (1 << CW) - 1) m_ops++;
          m_ldone = m_ldone | (lane_finished & m_mask);
          m_st = abort ? 0 : fin_all ? 3 : 2;
        end
        3: m_st = abort ? 0 : ((mpe_busy & m_mask) == 0) ? 4 : 3;
        default: m_st = 0;
      endcase
    end
  end
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        a = m_mask[i] && !m_ldone[i] && !(abort && m_st inside {1, 2, 3});
        e_rep[i] = a && (m_st == 1 ? !rep_filled[i] : m_st == 2 && is_index[i] && !unique_busy[i]);
        e_uni[i] = a && (m_st == 1 ? !unique_filled[i] : m_st == 2 && new_weight[i] && mpe_out_ready[i]);
        e_idx[i] = a && (m_st == 1 ? !idx_filled[i] : m_st == 2 && !rep_busy[i]);
        e_mpe[i] = a && m_st == 2 && weight_valid[i];
      end
      chk("state", state_o, m_st);
      chk("busy", busy, m_st != 0);
      chk("done", done, m_st == 4);
      chk("timeout_err", timeout_err, m_terr);
      chk("op_cycles", op_cycles, m_ops);
      chk("lane_done", lane_done, m_ldone);
      chk("rep_enable", rep_enable, e_rep);
      chk("unique_enable", unique_enable, e_uni);
      chk("idx_enable", idx_enable, e_idx);
      chk("mpe_enable", mpe_enable, e_mpe);
    end
  end
  task automatic step(); @(posedge clock); #1; endtask
  task automatic noise();
    mpe_out_ready = N'($urandom); weight_valid = N'($urandom); unique_busy = N'($urandom);
    new_weight = N'($urandom); rep_busy = N'($urandom); is_index = N'($urandom);
  endtask
  task automatic set_filled(input logic [N-1:0] v);
    rep_filled = v; unique_filled = v; idx_filled = v;
  endtask
  initial begin
    step(); step(); reset = 0; #1;
    chk("rst_state", state_o, 0);
    chk("rst_outs", {mpe_enable, unique_enable, rep_enable, idx_enable, lane_done, busy, done, timeout_err, op_cycles}, 0);
    // full four-lane run
    dc0 = done_cnt; start = 1; lane_mask = 4'hF; step(); start = 0;
    noise(); #1 chk("s1_fill", state_o, 1);
    step(); noise(); step(); noise(); set_filled(4'hF); step();
    mpe_busy = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      noise(); lane_finished = c == 5 ? 4'b0001 : c == 7 ? 4'b0110 : c == 10 ? 4'b1000 : 4'b0000;
      #1 chk("s1_operate", state_o, 2); step();
    end
    lane_finished = 0; #1 chk("s1_drain", state_o, 3);
    step(); mpe_busy = 0; #1 chk("s1_drain2", state_o, 3);
    step(); chk("s1_done", done, 1); chk("s1_ops", op_cycles, 10); chk("s1_ldone", lane_done, 4'hF);
    step(); chk("s1_idle", state_o, 0); chk("s1_pulses", done_cnt - dc0, 1);
    // partial mask: unmasked lanes must stay silent
    dc0 = done_cnt; leak = 0; set_filled(0); start = 1; lane_mask = 4'b0101; step(); start = 0; set_filled(4'b0101);
    for (int c = 0; c < 8; c++) begin
      noise(); lane_finished = c == 2 ? 4'b0001 : c == 3 ? 4'b0100 : 4'b0000;
      #1 leak = leak | ((mpe_enable | unique_enable | rep_enable | idx_enable) & 4'b1010); step();
    end
    lane_finished = 0;
    chk("s2_leak", leak, 0); chk("s2_ldone", lane_done, 4'b0101); chk("s2_pulses", done_cnt - dc0, 1); chk("s2_idle", state_o, 0);
    // fill timeout with lane 2 idx never filled
    dc0 = done_cnt; set_filled(4'hF); idx_filled[2] = 0; start = 1; lane_mask = 4'hF; step(); start = 0;
    for (int k = 0; k < FT; k++) begin
      noise(); #1 chk("s3_idx2", idx_enable[2], 1); chk("s3_fill", state_o, 1); step();
    end
    chk("s3_idle", state_o, 0); chk("s3_terr", timeout_err, 1); chk("s3_nodone", done_cnt - dc0, 0);
    // per-lane operate enables
    set_filled(4'hF); start = 1; lane_mask = 4'b0011; step(); start = 0; step();
    is_index = 4'h1; unique_busy = 0; new_weight = 4'h1; mpe_out_ready = 0; rep_busy = 4'h1; lane_finished = 4'h1;
    #1 chk("s4_rep0", rep_enable[0], 1); chk("s4_uni0", unique_enable[0], 0); chk("s4_idx0", idx_enable[0], 0);
    step(); lane_finished = 0; #1 chk("s4_off0", {mpe_enable[0], unique_enable[0], rep_enable[0], idx_enable[0]}, 0);
    chk("s4_operate", state_o, 2);
    lane_finished = 4'h2; step(); lane_finished = 0; step(); step();
    chk("s4_idle", state_o, 0);
    // abort in OPERATE cycle 4
    dc0 = done_cnt; start = 1; lane_mask = 4'hF; step(); start = 0; step(); step(); step(); step();
    is_index = 4'hF; unique_busy = 0; new_weight = 4'hF; mpe_out_ready = 4'hF; weight_valid = 4'hF; rep_busy = 0; abort = 1;
    #1 chk("s5_op4", state_o, 2); chk("s5_en", {mpe_enable, unique_enable, rep_enable, idx_enable}, 0);
    step(); abort = 0; chk("s5_idle", state_o, 0); chk("s5_nodone", done_cnt - dc0, 0);
    start = 1; step(); start = 0; #1 chk("s5_ops_clr", op_cycles, 0); chk("s5_fill", state_o, 1);
    abort = 1; step(); abort = 0; chk("s5_idle2", state_o, 0);
    // empty mask
    dc0 = done_cnt; start = 1; lane_mask = 0; step(); start = 0;
    chk("s6_done", state_o, 4); chk("s6_pulse", done, 1); chk("s6_en", {mpe_enable, unique_enable, rep_enable, idx_enable}, 0);
    step(); chk("s6_idle", state_o, 0); chk("s6_pulses", done_cnt - dc0, 1);
    // op_cycles saturation
    start = 1; lane_mask = 4'h1; step(); start = 0; step();
    repeat (20) begin noise(); step(); end
    chk("s7_sat", op_cycles, (1 << CW) - 1); chk("s7_operate", state_o, 2);
    lane_finished = 4'h1; step(); lane_finished = 0; step(); step(); chk("s7_idle", state_o, 0);
    // random traffic, including mid-run reset and abort
    repeat (4000) begin
      noise();
      reset = $urandom_range(399) == 0; start = $urandom_range(2) == 0; abort = $urandom_range(39) == 0;
      lane_mask = N'($urandom);
      if ($urandom_range(2) == 0) set_filled(4'hF);
      else begin rep_filled = N'($urandom); unique_filled = N'($urandom); idx_filled = N'($urandom); end
      lane_finished = N'($urandom & $urandom & $urandom);
      mpe_busy = N'($urandom & $urandom);
      step();
    end
    reset = 0; start = 0; abort = 0; step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
